fitness_eval_ctrl: RTL and testbench
====================================

Name: fitness_eval_ctrl

Overview:
Sequences one fitness evaluation of the evolvable circuit for the HPS-side genetic algorithm.
- HPS raises start_processing. The block pulses chrom_load, then applies up to NUM_SEQ input vectors to the circuit, waiting SETTLE_CYCLES for each.
- For each vector it compares circuit_out against the expected word, masked by the valid word, and accumulates mismatches into 8 per-nibble error sums.
- It then raises done_processing and holds it until the HPS acknowledges via done_feedback.
- Sits between the HPS PIO bank and the evolvable circuit fabric.

Parameters:
NUM_SEQ, 16, number of input/expected/valid vectors available
DATA_W, 32, width of each vector and of circuit_in/circuit_out
NUM_ERR, 8, number of error sums; each covers DATA_W/NUM_ERR bits (one nibble)
SETTLE_CYCLES, 4, cycles circuit_in is held before sampling; must be ≥1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start_processing  in  1  level request from HPS to run one evaluation
done_feedback  in  1  HPS acknowledge that error sums were read
sequences_to_process  in  32  number of vectors to evaluate
input_sequence  in  NUM_SEQ*DATA_W  flattened vectors; vector i = bits [i*DATA_W +: DATA_W]
expected_output  in  NUM_SEQ*DATA_W  flattened expected circuit outputs
valid_output  in  NUM_SEQ*DATA_W  flattened compare masks; 1 = bit is checked
circuit_out  in  DATA_W  evolvable circuit output
circuit_in  out  DATA_W  registered stimulus to evolvable circuit
chrom_load  out  1  one-cycle pulse: circuit latches chromosome segments
ready_to_process  out  1  high only in IDLE
done_processing  out  1  high only in DONE
error_sum  out  NUM_ERR*32  flattened accumulators; sum k = bits [k*32 +: 32]

Behaviour:
- Reset values: state = IDLE, circuit_in = 0, chrom_load = 0, done_processing = 0, ready_to_process = 1, all error_sum = 0, idx = 0, settle counter = 0.
- FSM states: IDLE, LOAD, APPLY, SAMPLE, DONE, RELEASE.
- IDLE:
  - start_processing = 1 (level-sampled) → LOAD.
  - n = min(sequences_to_process, NUM_SEQ) is latched at this transition.
- LOAD (exactly 1 cycle):
  - chrom_load = 1; all error_sum cleared to 0; idx = 0.
  - If n = 0 → DONE, else → APPLY.
- APPLY:
  - circuit_in = input_sequence[idx], registered on entry.
  - Held for exactly SETTLE_CYCLES cycles, then → SAMPLE.
- SAMPLE (1 cycle):
  - mismatch = (circuit_out ^ expected_output[idx]) & valid_output[idx].
  - For each k: error_sum[k] += popcount(mismatch[4k+3:4k]), i.e. adds 0..4.
  - If idx = n−1 → DONE, else idx+1 → APPLY.
- DONE:
  - done_processing = 1, circuit_in = 0, error_sum frozen.
  - done_feedback = 1 → RELEASE.
- RELEASE:
  - done_processing = 0.
  - Waits until start_processing = 0 and done_feedback = 0 → IDLE. This prevents a held start from re-triggering.
- Latency: start sampled at edge 0 → done_processing visible from cycle 2 + n*(SETTLE_CYCLES+1). Example: n=16, S=4 gives cycle 82; n=0 gives cycle 2.
- Widths: maximum sum is NUM_SEQ*4 = 64, so 32-bit accumulators never overflow; no saturation logic.
- Inputs other than start/feedback are sampled live. HPS must keep them stable from start until done.
- Dropping start_processing mid-run does not abort; the run completes.
- done_feedback outside DONE is ignored.
- reset asserted in any state immediately restores all reset values, including mid-APPLY.

Decomposition:
- Package fitness_eval_pkg:
  - state enum;
  - DATA_W, NUM_SEQ, NUM_ERR, ERR_W = 32, NIB_W = 4 constants;
  - function clamping sequences_to_process to NUM_SEQ.
- One sub-module, nibble_mismatch_count: combinational.
  - Inputs: out, expected, valid (DATA_W each).
  - Output: NUM_ERR 3-bit popcounts.
  - Instantiated once and fed the vector at idx.

Test Plan:
- Identity circuit model (circuit_out = circuit_in), n=2; seq0 = 0x000000FF, seq1 = 0x0; expected = 0; valid = 0xFFFFFFFF → done at cycle 12; error_sum[0] = 4, [1] = 4, others 0.
- Same stimulus with valid0 = 0x0000000F → error_sum[0] = 4, [1] = 0; checks masking.
- sequences_to_process = 0 → chrom_load pulse, done at cycle 2, all sums 0, circuit_in stays 0.
- sequences_to_process = 100, all vectors mismatching fully, valid = all ones → clamps to 16; each sum = 64; done at cycle 82.
- Hold start_processing = 1 through done and feedback → stays in RELEASE with ready_to_process = 0. Drop start → IDLE next cycle; a new start clears sums in LOAD.
- Assert reset during APPLY of vector 5 → next cycle all outputs at reset values, ready_to_process = 1; a subsequent run yields correct sums.

Source files
------------

// File: rtl/fitness_eval_pkg.sv
// Shared constants, FSM state type and helpers for the fitness evaluation controller.
package fitness_eval_pkg;

  localparam int DATA_W        = 32;
  localparam int NUM_SEQ       = 16;
  localparam int NUM_ERR       = 8;
  localparam int ERR_W         = 32;
  localparam int NIB_W         = 4;
  localparam int SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    SAMPLE,
    DONE,
    RELEASE
  } state_t;

  function automatic logic [31:0] clamp_seq_count(input logic [31:0] requested,
                                                  input int unsigned limit);
    return (requested > limit) ? limit : requested;
  endfunction

endpackage

// File: rtl/nibble_mismatch_count.sv
// Counts masked mismatching bits per nibble between a circuit output and its expected word.
module nibble_mismatch_count #(
  parameter int DATA_W  = 32,
  parameter int NUM_ERR = 8
) (
  input  logic [DATA_W-1:0]       out,
  input  logic [DATA_W-1:0]       expected,
  input  logic [DATA_W-1:0]       valid,
  output logic [NUM_ERR-1:0][2:0] counts
);
  import fitness_eval_pkg::*;

  logic [DATA_W-1:0] mismatch;

  assign mismatch = (out ^ expected) & valid;

  always_comb begin
    counts = '0;
    for (int k = 0; k < NUM_ERR; k++) begin
      for (int b = 0; b < NIB_W; b++) begin
        counts[k] = counts[k] + {2'b00, mismatch[k*NIB_W + b]};
      end
    end
  end

endmodule

// File: rtl/fitness_eval_ctrl.sv
// Runs one fitness evaluation: loads the chromosome, applies each vector, accumulates
// per-nibble mismatch counts, then handshakes the result back to the HPS.
module fitness_eval_ctrl #(
  parameter int NUM_SEQ       = 16,
  parameter int DATA_W        = 32,
  parameter int NUM_ERR       = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start_processing,
  input  logic                                       done_feedback,
  input  logic [31:0]                                sequences_to_process,
  input  logic [NUM_SEQ*DATA_W-1:0]                  input_sequence,
  input  logic [NUM_SEQ*DATA_W-1:0]                  expected_output,
  input  logic [NUM_SEQ*DATA_W-1:0]                  valid_output,
  input  logic [DATA_W-1:0]                          circuit_out,
  output logic [DATA_W-1:0]                          circuit_in,
  output logic                                       chrom_load,
  output logic                                       ready_to_process,
  output logic                                       done_processing,
  output logic [NUM_ERR*fitness_eval_pkg::ERR_W-1:0] error_sum
);
  import fitness_eval_pkg::*;

  localparam int IDX_W = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1;
  localparam int CNT_W = $clog2(NUM_SEQ + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [IDX_W-1:0]               next_idx;
  logic [CNT_W-1:0]               n_seq;
  logic [SET_W-1:0]               settle_cnt;
  logic [NUM_ERR-1:0][ERR_W-1:0]  sums;
  logic [NUM_ERR-1:0][2:0]        nib_counts;
  logic [DATA_W-1:0]              cur_expected;
  logic [DATA_W-1:0]              cur_valid;
  logic [DATA_W-1:0]              first_vec;
  logic [DATA_W-1:0]              next_vec;
  logic                           last_vec;

  assign next_idx     = idx + 1'b1;
  assign cur_expected = expected_output[idx*DATA_W +: DATA_W];
  assign cur_valid    = valid_output[idx*DATA_W +: DATA_W];
  assign first_vec    = input_sequence[DATA_W-1:0];
  assign next_vec     = input_sequence[next_idx*DATA_W +: DATA_W];
  assign last_vec     = (CNT_W'(idx) == (n_seq - CNT_W'(1)));
  assign error_sum    = sums;

  nibble_mismatch_count #(
    .DATA_W  (DATA_W),
    .NUM_ERR (NUM_ERR)
  ) u_mismatch (
    .out      (circuit_out),
    .expected (cur_expected),
    .valid    (cur_valid),
    .counts   (nib_counts)
  );

  // Outputs are registered on state entry so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      circuit_in       <= '0;
      chrom_load       <= 1'b0;
      done_processing  <= 1'b0;
      ready_to_process <= 1'b1;
      sums             <= '0;
      idx              <= '0;
      n_seq            <= '0;
      settle_cnt       <= '0;
    end else begin
      chrom_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start_processing) begin
            state            <= LOAD;
            n_seq            <= CNT_W'(clamp_seq_count(sequences_to_process, NUM_SEQ));
            chrom_load       <= 1'b1;
            ready_to_process <= 1'b0;
            idx              <= '0;
          end
        end
        LOAD: begin
          sums       <= '0;
          idx        <= '0;
          settle_cnt <= '0;
          if (n_seq == '0) begin
            state           <= DONE;
            done_processing <= 1'b1;
            circuit_in      <= '0;
          end else begin
            state      <= APPLY;
            circuit_in <= first_vec;
          end
        end
        APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          for (int k = 0; k < NUM_ERR; k++) begin
            sums[k] <= sums[k] + ERR_W'(nib_counts[k]);
          end
          if (last_vec) begin
            state           <= DONE;
            done_processing <= 1'b1;
            circuit_in      <= '0;
          end else begin
            state      <= APPLY;
            idx        <= next_idx;
            circuit_in <= next_vec;
          end
        end
        DONE: begin
          if (done_feedback) begin
            state           <= RELEASE;
            done_processing <= 1'b0;
          end
        end
        // A still-asserted start must not immediately launch another run.
        RELEASE: begin
          if (!start_processing && !done_feedback) begin
            state            <= IDLE;
            ready_to_process <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Scoreboard bench for fitness_eval_ctrl with an identity model of the evolvable circuit.
module tb_fitness_eval_ctrl;

  localparam int NUM_SEQ = 16;
  localparam int DATA_W  = 32;
  localparam int NUM_ERR = 8;
  localparam int SETTLE  = 4;

  typedef struct {
    int unsigned              cycles;
    logic [NUM_ERR*32-1:0]    sums;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          start_processing;
  logic                          done_feedback;
  logic [31:0]                   sequences_to_process;
  logic [NUM_SEQ*DATA_W-1:0]     input_sequence;
  logic [NUM_SEQ*DATA_W-1:0]     expected_output;
  logic [NUM_SEQ*DATA_W-1:0]     valid_output;
  logic [DATA_W-1:0]             circuit_out;
  logic [DATA_W-1:0]             circuit_in;
  logic                          chrom_load;
  logic                          ready_to_process;
  logic                          done_processing;
  logic [NUM_ERR*32-1:0]         error_sum;

  logic [DATA_W-1:0] in_seq  [NUM_SEQ];
  logic [DATA_W-1:0] exp_seq [NUM_SEQ];
  logic [DATA_W-1:0] val_seq [NUM_SEQ];

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  assign circuit_out = circuit_in;

  always_comb begin
    input_sequence  = '0;
    expected_output = '0;
    valid_output    = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      input_sequence[i*DATA_W +: DATA_W]  = in_seq[i];
      expected_output[i*DATA_W +: DATA_W] = exp_seq[i];
      valid_output[i*DATA_W +: DATA_W]    = val_seq[i];
    end
  end

  fitness_eval_ctrl #(
    .NUM_SEQ       (NUM_SEQ),
    .DATA_W        (DATA_W),
    .NUM_ERR       (NUM_ERR),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start_processing     (start_processing),
    .done_feedback        (done_feedback),
    .sequences_to_process (sequences_to_process),
    .input_sequence       (input_sequence),
    .expected_output      (expected_output),
    .valid_output         (valid_output),
    .circuit_out          (circuit_out),
    .circuit_in           (circuit_in),
    .chrom_load           (chrom_load),
    .ready_to_process     (ready_to_process),
    .done_processing      (done_processing),
    .error_sum            (error_sum)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Cycle numbering: the start-sampling edge is cycle 0, so done shows up at 2 + n*(S+1).
  function automatic exp_t model(input logic [31:0] req);
    exp_t              e;
    int                n;
    logic [DATA_W-1:0] mm;
    n        = (req > 32'(NUM_SEQ)) ? NUM_SEQ : int'(req);
    e.cycles = 2 + n * (SETTLE + 1);
    e.sums   = '0;
    for (int i = 0; i < n; i++) begin
      mm = (in_seq[i] ^ exp_seq[i]) & val_seq[i];
      for (int k = 0; k < NUM_ERR; k++) begin
        for (int b = 0; b < 4; b++) begin
          e.sums[k*32 +: 32] = e.sums[k*32 +: 32] + 32'(mm[k*4 + b]);
        end
      end
    end
    return e;
  endfunction

  task automatic finishRun(input bit hold_start);
    @(negedge clk);
    done_feedback = 1'b1;
    @(posedge clk);
    @(negedge clk);
    done_feedback = 1'b0;
    checkOutput("done_cleared", 64'(done_processing), 64'd0);
    if (hold_start) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("held_start_ready", 64'(ready_to_process), 64'd0);
      start_processing = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_back", 64'(ready_to_process), 64'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] req, input bit hold_start);
    exp_t              e;
    int                cyc;
    bit                seen;
    logic [DATA_W-1:0] in_or;
    sequences_to_process = req;
    sb.push_back(model(req));
    @(negedge clk);
    start_processing = 1'b1;
    @(posedge clk);
    cyc   = 0;
    seen  = 1'b0;
    in_or = '0;
    repeat (200) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start_processing = 1'b0;
      in_or |= circuit_in;
      if (cyc == 1) checkOutput("chrom_load_high", 64'(chrom_load), 64'd1);
      if (cyc == 2) begin
        checkOutput("chrom_load_low", 64'(chrom_load), 64'd0);
        checkOutput("sums_cleared", 64'(error_sum == '0), 64'd1);
      end
      if (done_processing) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
    end
    e = sb.pop_front();
    if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
    checkOutput("done_cycle", 64'(cyc), 64'(e.cycles));
    for (int k = 0; k < NUM_ERR; k++) begin
      checkOutput($sformatf("sum%0d", k), 64'(error_sum[k*32 +: 32]), 64'(e.sums[k*32 +: 32]));
    end
    checkOutput("circuit_in_done", 64'(circuit_in), 64'd0);
    checkOutput("ready_busy", 64'(ready_to_process), 64'd0);
    if (e.cycles == 2) checkOutput("circuit_in_never_driven", 64'(in_or), 64'd0);
    finishRun(hold_start);
  endtask

  initial begin
    reset                = 1'b1;
    start_processing     = 1'b0;
    done_feedback        = 1'b0;
    sequences_to_process = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      in_seq[i]  = '0;
      exp_seq[i] = '0;
      val_seq[i] = '1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", 64'(ready_to_process), 64'd1);
    checkOutput("rst_done", 64'(done_processing), 64'd0);
    checkOutput("rst_chrom", 64'(chrom_load), 64'd0);
    checkOutput("rst_circuit_in", 64'(circuit_in), 64'd0);
    checkOutput("rst_sums", 64'(error_sum == '0), 64'd1);
    reset = 1'b0;

    in_seq[0] = 32'h0000_00FF;
    applyStimulus(32'd2, 1'b0);

    val_seq[0] = 32'h0000_000F;
    applyStimulus(32'd2, 1'b0);

    applyStimulus(32'd0, 1'b0);

    for (int i = 0; i < NUM_SEQ; i++) begin
      in_seq[i]  = $urandom();
      exp_seq[i] = ~in_seq[i];
      val_seq[i] = '1;
    end
    applyStimulus(32'd100, 1'b1);

    for (int i = 0; i < NUM_SEQ; i++) begin
      in_seq[i]  = $urandom();
      exp_seq[i] = $urandom();
      val_seq[i] = $urandom();
    end
    applyStimulus(32'd7, 1'b0);

    // Abort a full-length run while vector 5 is being applied.
    sequences_to_process = 32'd16;
    @(negedge clk);
    start_processing = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_processing = 1'b0;
    repeat (27) @(posedge clk);
    @(negedge clk);
    checkOutput("apply_vec5", 64'(circuit_in), 64'(in_seq[5]));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ready", 64'(ready_to_process), 64'd1);
    checkOutput("abort_done", 64'(done_processing), 64'd0);
    checkOutput("abort_chrom", 64'(chrom_load), 64'd0);
    checkOutput("abort_circuit_in", 64'(circuit_in), 64'd0);
    checkOutput("abort_sums", 64'(error_sum == '0), 64'd1);
    reset = 1'b0;

    applyStimulus(32'd16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
